// File: rtl/ask_demod.sv
// Non-coherent ASK demodulator: rectifies each sample, integrates the magnitude
// over SPS samples, and slices the per-symbol sum into a 2-bit amplitude symbol.
module ask_demod #(
  parameter int unsigned SPS   = 50,
  parameter int unsigned ACC_W = 18,
  parameter int unsigned TH1   = 17000,
  parameter int unsigned TH2   = 51000,
  parameter int unsigned TH3   = 85000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ask_valid_i,
  input  logic signed [11:0] ask_din,
  output logic [1:0]         sym_dout,
  output logic               sym_valid_o,
  output logic               sym_abort_o,
  output logic [15:0]        sym_cnt
);

  typedef enum logic {
    IDLE,
    INTEG
  } state_e;

  localparam logic [7:0]       LAST  = 8'(SPS - 1);
  localparam logic [ACC_W-1:0] TH1_C = ACC_W'(TH1);
  localparam logic [ACC_W-1:0] TH2_C = ACC_W'(TH2);
  localparam logic [ACC_W-1:0] TH3_C = ACC_W'(TH3);

  state_e           state_q, state_d;
  logic [10:0]      mag_q, mag_d;
  logic             mag_vld_q, mag_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       sym_q, sym_d;
  logic             sym_valid_q, sym_valid_d;
  logic             sym_abort_q, sym_abort_d;
  logic [15:0]      sym_cnt_q, sym_cnt_d;

  logic [11:0]      din_u;
  logic [11:0]      din_neg;
  logic [ACC_W-1:0] sum;
  logic [1:0]       slice_sym;

  // Stage 1: rectify; -2048 has no positive 12-bit twin, so it clips to 2047
  always_comb begin
    din_u     = ask_din;
    din_neg   = (~din_u) + 12'd1;
    mag_vld_d = ask_valid_i;
    if (!din_u[11]) begin
      mag_d = din_u[10:0];
    end else if (din_u == 12'h800) begin
      mag_d = 11'h7FF;
    end else begin
      mag_d = din_neg[10:0];
    end
  end

  always_comb begin
    sum = acc_q + ACC_W'(mag_q);
    if (sum >= TH3_C) begin
      slice_sym = 2'd3;
    end else if (sum >= TH2_C) begin
      slice_sym = 2'd2;
    end else if (sum >= TH1_C) begin
      slice_sym = 2'd1;
    end else begin
      slice_sym = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      mag_vld_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_abort_q <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      mag_vld_q   <= mag_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_abort_q <= sym_abort_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mag_vld_q)  state_d = INTEG;
      INTEG:   if (!mag_vld_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // After a dump cnt is 0 and state stays INTEG, so the next sample opens a
  // new symbol through the ordinary accumulate path with no gap.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    sym_abort_d = 1'b0;
    sym_cnt_d   = sym_cnt_q;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (mag_vld_q) begin
          acc_d = ACC_W'(mag_q);
          cnt_d = 8'd1;
        end
      end
      INTEG: begin
        if (mag_vld_q) begin
          if (cnt_q == LAST) begin
            sym_d       = slice_sym;
            sym_valid_d = 1'b1;
            sym_cnt_d   = sym_cnt_q + 16'd1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          sym_abort_d = (cnt_q != 8'd0);
          acc_d       = '0;
          cnt_d       = '0;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  assign sym_dout    = sym_q;
  assign sym_valid_o = sym_valid_q;
  assign sym_abort_o = sym_abort_q;
  assign sym_cnt     = sym_cnt_q;

endmodule

// File: tb/tb_ask_demod.sv
// Self-checking bench for ask_demod: directed boundary cases plus randomized
// bursts, checked every cycle against a frame-level behavioural model.
module tb_ask_demod;

  localparam int SPS = 50;
  localparam int TH1 = 17000;
  localparam int TH2 = 51000;
  localparam int TH3 = 85000;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               ask_valid_i = 1'b0;
  logic signed [11:0] ask_din = '0;
  logic [1:0]         sym_dout;
  logic               sym_valid_o;
  logic               sym_abort_o;
  logic [15:0]        sym_cnt;

  ask_demod #(.SPS(SPS), .ACC_W(18), .TH1(TH1), .TH2(TH2), .TH3(TH3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ask_valid_i(ask_valid_i),
    .ask_din    (ask_din),
    .sym_dout   (sym_dout),
    .sym_valid_o(sym_valid_o),
    .sym_abort_o(sym_abort_o),
    .sym_cnt    (sym_cnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: magnitudes of the open frame, plus events scheduled by cycle number
  int frame[$];
  bit exp_v[int];
  bit exp_a[int];
  int exp_s[int];
  int held = 0;
  int mcnt = 0;
  int dec_q[$];
  int abort_seen = 0;

  function automatic int slice(input int s);
    if (s >= TH3) return 3;
    if (s >= TH2) return 2;
    if (s >= TH1) return 1;
    return 0;
  endfunction

  function automatic int magnitude(input int d);
    int m;
    m = (d < 0) ? -d : d;
    return (m > 2047) ? 2047 : m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one sample for one cycle; the model decides its consequences.
  task automatic drive(input bit v, input int d);
    int s;
    ask_valid_i = v;
    ask_din     = 12'(d);
    if (rstn) begin
      if (v) begin
        frame.push_back(magnitude(d));
        if (frame.size() == SPS) begin
          s = 0;
          foreach (frame[i]) s += frame[i];
          exp_v[cyc + 2] = 1'b1;
          exp_s[cyc + 2] = slice(s);
          frame.delete();
        end
      end else if (frame.size() != 0) begin
        exp_a[cyc + 2] = 1'b1;
        frame.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic symbol(input int d);
    for (int i = 0; i < SPS; i++) drive(1'b1, d);
  endtask

  task automatic do_reset(input int n);
    rstn        = 1'b0;
    ask_valid_i = 1'b0;
    frame.delete();
    exp_v.delete();
    exp_a.delete();
    exp_s.delete();
    held = 0;
    mcnt = 0;
    #1;
    check("rst_sym_dout", sym_dout, 0);
    check("rst_sym_cnt", sym_cnt, 0);
    check("rst_valid", sym_valid_o, 0);
    check("rst_abort", sym_abort_o, 0);
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    bit ev;
    bit ea;
    ev = exp_v.exists(cyc);
    ea = exp_a.exists(cyc);
    if (ev) begin
      held = exp_s[cyc];
      mcnt = (mcnt + 1) % 65536;
    end
    check("sym_valid_o", sym_valid_o, ev);
    check("sym_abort_o", sym_abort_o, ea);
    check("sym_dout", sym_dout, held);
    check("sym_cnt", sym_cnt, mcnt);
    if (sym_valid_o) dec_q.push_back(sym_dout);
    if (sym_abort_o) abort_seen++;
  end

  initial begin
    #(5_000_000);
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e2[4];
    int e3[3];
    int kind, base, len, gap, d;
    e2 = '{0, 1, 2, 3};
    e3 = '{3, 1, 0};

    #1;
    rstn = 1'b0;
    repeat (5) @(posedge clk);
    #9;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single symbol of 500: sum 25000 -> 1
    symbol(500);
    idle(4);
    check("t1_sym", sym_dout, 1);
    check("t1_cnt", sym_cnt, 1);
    check("t1_npulse", dec_q.size(), 1);

    // Back-to-back symbols: sums 5000, 35000, 60000, 102350
    dec_q.delete();
    symbol(-100);
    symbol(700);
    symbol(-1200);
    symbol(2047);
    idle(4);
    check("t2_ndec", dec_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_dec", (i < dec_q.size()) ? dec_q[i] : -1, e2[i]);

    // Saturation and exact threshold edges
    dec_q.delete();
    symbol(-2048);
    idle(2);
    symbol(340);
    idle(2);
    for (int i = 0; i < SPS - 1; i++) drive(1'b1, 340);
    drive(1'b1, 339);
    idle(4);
    check("t3_ndec", dec_q.size(), 3);
    for (int i = 0; i < 3; i++) check("t3_dec", (i < dec_q.size()) ? dec_q[i] : -1, e3[i]);

    // Abort after 30 samples; last decision (0) must be held
    dec_q.delete();
    for (int i = 0; i < 30; i++) drive(1'b1, 1000);
    idle(4);
    check("t4_aborts", abort_seen, 1);
    check("t4_ndec", dec_q.size(), 0);
    check("t4_held", sym_dout, 0);
    symbol(1800);
    idle(4);
    check("t4_sym", sym_dout, 3);

    // Reset at sample 25 of a symbol, then a fresh symbol of 1000
    for (int i = 0; i < 25; i++) drive(1'b1, 1000);
    do_reset(3);
    symbol(1000);
    idle(4);
    check("t5_sym", sym_dout, 1);
    check("t5_cnt", sym_cnt, 1);
    check("t5_aborts", abort_seen, 1);

    // Randomized bursts, partial symbols, gaps and resets
    for (int n = 0; n < 220; n++) begin
      kind = $urandom_range(0, 99);
      base = $urandom_range(0, 2047);
      if (kind < 80) begin
        for (int i = 0; i < SPS; i++) begin
          d = base + $urandom_range(0, 40) - 20;
          if ($urandom_range(0, 1)) d = -d;
          if (d > 2047) d = 2047;
          if (d < -2048) d = -2048;
          drive(1'b1, d);
        end
        gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        idle(gap);
      end else if (kind < 95) begin
        len = $urandom_range(1, SPS - 1);
        for (int i = 0; i < len; i++) drive(1'b1, int'($urandom_range(0, 4095)) - 2048);
        idle($urandom_range(1, 3));
      end else begin
        len = $urandom_range(0, SPS - 1);
        for (int i = 0; i < len; i++) drive(1'b1, base);
        do_reset($urandom_range(1, 3));
      end
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ask_demod.md
# ask_demod

Non-coherent ASK demodulator that sits directly downstream of `ask_mod` and consumes its signed 12-bit sample stream and valid. Each symbol period is a fixed number of samples. Per period the block rectifies the samples, integrates the magnitude (integrate-and-dump), and slices the sum against three thresholds to recover the 2-bit amplitude symbol. It closes the loop for modulator loop-back benches and forms the receive front of the link.

## Interface

Parameters:
- `SPS`, default 50: samples per symbol (1000 ns symbol at 50 MHz); legal range 2..255.
- `ACC_W`, default 18: accumulator width; must hold 2047*SPS.
- `TH1`, default 17000: slicer threshold between symbols 0 and 1.
- `TH2`, default 51000: slicer threshold between symbols 1 and 2.
- `TH3`, default 85000: slicer threshold between symbols 2 and 3.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `rstn` input 1: asynchronous active-low reset.
- `ask_valid_i` input 1: sample valid, driven from `ask_mod.ask_valid_o`.
- `ask_din` input 12, signed: sample, driven from `ask_mod.ask_dout`.
- `sym_dout` output 2: recovered symbol; holds its value until the next decision.
- `sym_valid_o` output 1: one-cycle pulse when `sym_dout` is updated.
- `sym_abort_o` output 1: one-cycle pulse when a partial symbol is discarded.
- `sym_cnt` output 16: count of decided symbols; wraps modulo 2^16.

## Operation

Reset:
- All outputs and internal registers go to 0, asynchronously.
- The FSM goes to IDLE.

Stage 1, rectify (registered):
- `mag = |ask_din|`, 11-bit unsigned.
- -2048 saturates to 2047.
- `mag_vld` is `ask_valid_i` delayed by one cycle.

Stage 2, FSM:
- IDLE:
  - Accumulator (`acc`) = 0 and sample counter (`cnt`) = 0.
  - On `mag_vld`=1: `acc <= mag`, `cnt <= 1`, go to INTEG.
- INTEG, `mag_vld`=1 and `cnt` < SPS-1: `acc += mag`, `cnt++`.
- INTEG, `mag_vld`=1 and `cnt` = SPS-1 (last sample):
  - `sum = acc + mag`; this is the dump.
  - Register the slicer result of `sum` into `sym_dout`.
  - Pulse `sym_valid_o`, increment `sym_cnt`.
  - `acc <= 0`, `cnt <= 0`, stay in INTEG. The next sample opens the next symbol with no gap.
- INTEG, `mag_vld`=0 with `cnt` ≠ 0 (burst ended mid-symbol):
  - Pulse `sym_abort_o`.
  - Clear `acc` and `cnt`, go to IDLE.
  - No decision is made and `sym_dout` is unchanged.
- INTEG, `mag_vld`=0 with `cnt` = 0 (clean end of burst): go to IDLE with no pulse.

Slicer, on `sum` as unsigned:
- `sum` < TH1 gives symbol 0.
- TH1 ≤ `sum` < TH2 gives symbol 1.
- TH2 ≤ `sum` < TH3 gives symbol 2.
- `sum` ≥ TH3 gives symbol 3.
- Equality with a threshold selects the higher symbol.

Width rules:
- `acc` is ACC_W bits unsigned and never overflows for legal SPS.
- Thresholds are compared at ACC_W bits.

Symbol framing:
- Framing is anchored to the first valid sample after IDLE; no timing recovery is done.
- `ask_mod` must hold each symbol for exactly SPS valid samples.

## Timing

- Latency: the last (SPS-th) sample of a symbol is presented on `ask_din` in cycle c. `sym_valid_o` and the new `sym_dout` are high or valid in cycle c+2.
- Throughput: one decision every SPS cycles under continuous valid. Pulses are exactly SPS cycles apart.
- Pulse width: `sym_valid_o` and `sym_abort_o` are each high for exactly one cycle. They are never high in the same cycle.
- Valid drop: if `ask_valid_i` first goes low in cycle d while a symbol is partial, `sym_abort_o` pulses in cycle d+2.
- Valid rising again: a new symbol starts with the first valid sample. The first decision comes SPS+1 cycles after that sample's cycle.
- Reset mid-symbol: asserting `rstn`=0 clears everything immediately with no pulse. After release, the first valid sample starts a fresh symbol.

## Test plan

1. Reset, then constant `ask_din`=500 with `ask_valid_i`=1 for 50 cycles.
   - `sum`=25000 gives `sym_dout`=1.
   - `sym_valid_o` pulses once, 2 cycles after the 50th sample.
   - `sym_cnt`=1.
2. Four back-to-back symbols of constant -100, 700, -1200, 2047 (50 samples each).
   - Sums 5000, 35000, 60000, 102350.
   - Decisions 0, 1, 2, 3.
   - Pulses exactly 50 cycles apart.
3. Boundaries:
   - Constant -2048 for 50 samples: magnitude saturates, sum 102350, symbol 3.
   - 50 samples summing exactly 17000 (49×340 + 340): symbol 1.
   - 50 samples summing 16999: symbol 0.
4. Abort:
   - Valid for 30 samples, then low. `sym_abort_o` pulses once, there is no `sym_valid_o`, and `sym_dout` keeps its old value.
   - Then 50 samples of 1800 (sum 90000): symbol 3.
5. Assert `rstn` low at sample 25 of a symbol.
   - Outputs go to 0 immediately.
   - After release, a full 50-sample symbol of 1000 (sum 50000) decodes as 1.
6. Loop-back with `ask_mod`:
   - Reset released at 100 ns, 50 MHz clock.
   - Drive 500 random 2-bit symbols at 1000 ns each into `ask_mod` and feed its `ask_dout`/`ask_valid_o` into this block.
   - The recovered symbol sequence must equal the transmitted sequence, offset by the modulator latency.
   - `sym_cnt`=500, with zero aborts.
